if_stage: RTL and testbench

Instruction-fetch stage of the MeMIPS core. It owns the program counter and issues one word request per cycle to the synchronous instruction memory. It buffers returned instructions in a 2-entry queue and hands them to the decode stage over a valid/ready handshake. Branch/jump redirects from downstream flush the queue and discard in-flight responses.

---
 rtl/if_stage.sv | 111 +++++++++++
 tb/tb_if_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// MeMIPS instruction-fetch stage: PC, imem requests, 2-entry
// instruction queue, valid/ready to decode, redirect flush.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_exc_adel
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  entry_t      q0;
  entry_t      q1;
  logic [1:0]  occ;
  logic [31:0] pc;
  logic        epoch;
  logic        infl;
  logic [31:0] infl_pc;
  logic        infl_ep;

  logic        redir;
  logic [31:0] fpc;
  logic        pop;
  logic        push;
  logic [1:0]  occ_eff;
  logic [2:0]  demand;
  entry_t      new_e;

  // Fetch PC, issue decision and the entry built from a response
  always_comb begin
    redir   = br_valid && !rst;
    fpc     = redir ? br_target : pc;
    id_valid = (occ != 2'd0) && !rst;
    pop     = id_valid && id_ready;
    occ_eff = redir ? 2'd0 : (occ - {1'b0, pop});
    demand  = {1'b0, occ_eff} + {2'b00, infl};
    imem_req  = !rst && (demand < 3'd2);
    imem_addr = {fpc[31:2], 2'b00};
    push = infl && !redir && !rst && (infl_ep == epoch);
    new_e.pc   = infl_pc;
    new_e.adel = |infl_pc[1:0];
    new_e.inst = new_e.adel ? 32'h0 : imem_rdata;
    id_pc       = q0.pc;
    id_inst     = q0.inst;
    id_exc_adel = q0.adel;
  end

  // PC, epoch and in-flight request tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_PC;
      epoch   <= 1'b0;
      infl    <= 1'b0;
      infl_pc <= 32'h0;
      infl_ep <= 1'b0;
    end else begin
      pc      <= imem_req ? fpc + 32'd4 : fpc;
      epoch   <= epoch ^ redir;
      infl    <= imem_req;
      infl_pc <= fpc;
      infl_ep <= epoch ^ redir;
    end
  end

  // Two-entry queue with q0 as head; redirect empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      q0  <= '0;
      q1  <= '0;
      occ <= 2'd0;
    end else if (redir) begin
      occ <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (occ == 2'd2) begin
            q0 <= q1;
            q1 <= new_e;
          end else begin
            q0 <= new_e;
          end
        end
        2'b01: begin
          q0  <= q1;
          occ <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) q0 <= new_e;
          else             q1 <= new_e;
          occ <= occ + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage with a
// one-cycle-latency instruction memory model.
module tb_if_stage;

  localparam logic [31:0] K = 32'h5A5A_5A5A;
  localparam logic [31:0] B = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        br_valid;
  logic [31:0] br_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_exc_adel;

  int asserts = 0;
  int fails   = 0;
  int row     = 0;

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        eadel;
    logic        chk;
  } row_t;

  row_t tbl[$];

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .br_valid(br_valid), .br_target(br_target),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst),
    .id_exc_adel(id_exc_adel)
  );

  always #5 clk = ~clk;

  // memory: word at addr is addr^K, junk when not requested
  always @(posedge clk)
    imem_rdata <= imem_req ? (imem_addr ^ K) : 32'hDEAD_BEEF;

  function automatic row_t mk(
    input logic r, input logic br, input logic [31:0] tgt,
    input logic rdy, input logic ereq, input logic [31:0] eaddr,
    input logic ev, input logic [31:0] epc, input logic eadel,
    input logic chk);
    row_t v;
    v.rst = r; v.br = br; v.tgt = tgt; v.rdy = rdy;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = ev;
    v.epc = epc; v.eadel = eadel; v.chk = chk;
    v.einst = (eadel || !ev) ? 32'h0 : (epc ^ K);
    return v;
  endfunction

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h",
               nm, row, act, exp);
    end
  endtask

  task automatic apply(input row_t v);
    rst = v.rst; br_valid = v.br;
    br_target = v.tgt; id_ready = v.rdy;
    @(negedge clk);
    check("imem_req", {31'b0, imem_req}, {31'b0, v.ereq});
    if (v.ereq) check("imem_addr", imem_addr, v.eaddr);
    check("id_valid", {31'b0, id_valid}, {31'b0, v.evalid});
    if (v.chk) begin
      check("id_pc", id_pc, v.epc);
      check("id_inst", id_inst, v.einst);
      check("id_exc_adel", {31'b0, id_exc_adel},
            {31'b0, v.eadel});
    end
    @(posedge clk); #1;
    row++;
  endtask

  initial begin
    rst = 1'b1; br_valid = 1'b0;
    br_target = 32'h0; id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset, startup latency, streaming
    tbl.push_back(mk(1,0,0,1, 0,0,        0,0,0,1));
    tbl.push_back(mk(0,0,0,1, 1,B,        0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,B+4,      0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,B+8,      1,B,0,1));
    tbl.push_back(mk(0,0,0,1, 1,B+'hC,    1,B+4,0,1));
    tbl.push_back(mk(0,0,0,1, 1,B+'h10,   1,B+8,0,1));
    // stall four cycles, then release
    tbl.push_back(mk(0,0,0,0, 0,0,        1,B+'hC,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,        1,B+'hC,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,        1,B+'hC,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,        1,B+'hC,0,1));
    tbl.push_back(mk(0,0,0,1, 1,B+'h14,   1,B+'hC,0,1));
    tbl.push_back(mk(0,0,0,1, 1,B+'h18,   1,B+'h10,0,1));
    tbl.push_back(mk(0,0,0,1, 1,B+'h1C,   1,B+'h14,0,1));
    // redirect with queued entry and response in flight
    tbl.push_back(mk(0,1,32'h8000_0100,0,
                     1,32'h8000_0100, 1,B+'h18,0,1));
    tbl.push_back(mk(0,0,0,0, 1,32'h8000_0104, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_0108,
                     1,32'h8000_0100,0,1));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_010C,
                     1,32'h8000_0104,0,1));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_0110,
                     1,32'h8000_0108,0,1));
    // redirect in the same cycle as a transfer
    tbl.push_back(mk(0,1,32'h8000_0200,1,
                     1,32'h8000_0200, 1,32'h8000_010C,0,1));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_0204, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_0208,
                     1,32'h8000_0200,0,1));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_020C,
                     1,32'h8000_0204,0,1));
    // misaligned redirect target
    tbl.push_back(mk(0,1,32'h8000_0102,1,
                     1,32'h8000_0100, 1,32'h8000_0208,0,1));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_0104, 0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_0108,
                     1,32'h8000_0102,1,1));
    tbl.push_back(mk(0,0,0,1, 1,32'h8000_010C,
                     1,32'h8000_0106,1,1));
    // one-cycle reset with a request in flight
    tbl.push_back(mk(1,0,0,1, 0,0,        0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,B,        0,0,0,1));
    tbl.push_back(mk(0,0,0,1, 1,B+4,      0,0,0,0));
    tbl.push_back(mk(0,0,0,1, 1,B+8,      1,B,0,1));
    tbl.push_back(mk(0,0,0,1, 1,B+'hC,    1,B+4,0,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // pc wrap past 2^32
    apply(mk(0,1,32'hFFFF_FFF8,1,
             1,32'hFFFF_FFF8, 1,B+8,0,1));
    apply(mk(0,0,0,1, 1,32'hFFFF_FFFC, 0,0,0,0));
    apply(mk(0,0,0,1, 1,32'h0, 1,32'hFFFF_FFF8,0,1));
    apply(mk(0,0,0,1, 1,32'h4, 1,32'hFFFF_FFFC,0,1));
    // fill the queue, then redirect while stalled
    apply(mk(0,0,0,0, 0,0, 1,32'h0,0,1));
    apply(mk(0,0,0,0, 0,0, 1,32'h0,0,1));
    apply(mk(0,1,32'h8000_0100,0,
             1,32'h8000_0100, 1,32'h0,0,1));
    apply(mk(0,0,0,1, 1,32'h8000_0104, 0,0,0,0));
    apply(mk(0,0,0,1, 1,32'h8000_0108,
             1,32'h8000_0100,0,1));
    apply(mk(0,0,0,1, 1,32'h8000_010C,
             1,32'h8000_0104,0,1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
